// File: rtl/beta_alu_pkg.sv
// rtl/beta_alu_pkg.sv - shared Beta ALU types and constants (state set depends on BETA_DIV_SIGNED_EN)
package beta_alu_pkg;

    localparam int BETA_WIDTH     = 32;
    localparam int BETA_MAX_WIDTH = 128;

    // Sliced down to the instance width for divide-by-zero quotients.
    localparam logic [BETA_MAX_WIDTH-1:0] BETA_ALL_ONES = '1;

`ifdef BETA_DIV_SIGNED_EN
    typedef enum logic [2:0] {IDLE, PRE, DIVIDE, POST, DONE} div_state_t;
`else
    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} div_state_t;
`endif

endpackage

// File: rtl/beta_div_step.sv
// rtl/beta_div_step.sv - one restoring-division step: trial subtract and quotient bit
module beta_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // With rem < den held between steps, trial[WIDTH] is exactly the borrow.
    assign trial    = {rem, q_msb} - {1'b0, den};
    assign q_bit    = ~trial[WIDTH];
    assign rem_next = trial[WIDTH] ? {rem[WIDTH-2:0], q_msb} : trial[WIDTH-1:0];

endmodule

// File: rtl/beta_div.sv
// rtl/beta_div.sv - iterative restoring divider, one quotient bit per cycle; BETA_DIV_SIGNED_EN selects signed operands
module beta_div
    import beta_alu_pkg::*;
#(
    parameter int WIDTH = BETA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] DZ_QUOTIENT = BETA_ALL_ONES[WIDTH-1:0];

    div_state_t state, state_next;

    logic [WIDTH-1:0] rem_r, q_r, d_r, dividend_r;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             dz_r;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
`ifdef BETA_DIV_SIGNED_EN
    logic             sign_q, sign_r;
`endif

    beta_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .q_msb    (q_r[WIDTH-1]),
        .den      (d_r),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef BETA_DIV_SIGNED_EN
                    state_next = PRE;
`else
                    state_next = DIVIDE;
`endif
                end
            end
`ifdef BETA_DIV_SIGNED_EN
            PRE:    state_next = DIVIDE;
            DIVIDE: if (last) state_next = POST;
            POST:   state_next = DONE;
`else
            DIVIDE: if (last) state_next = DONE;
`endif
            DONE:   if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r       <= '0;
            q_r         <= '0;
            d_r         <= '0;
            dividend_r  <= '0;
            cnt         <= '0;
            last        <= 1'b0;
            dz_r        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef BETA_DIV_SIGNED_EN
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem_r      <= '0;
                        q_r        <= dividend;
                        d_r        <= divisor;
                        dividend_r <= dividend;
                        dz_r       <= (divisor == '0);
                        cnt        <= CW'(WIDTH - 1);
                        last       <= 1'b0;
                    end
                end
`ifdef BETA_DIV_SIGNED_EN
                PRE: begin
                    sign_q <= q_r[WIDTH-1] ^ d_r[WIDTH-1];
                    sign_r <= q_r[WIDTH-1];
                    q_r    <= q_r[WIDTH-1] ? -q_r : q_r;
                    d_r    <= d_r[WIDTH-1] ? -d_r : d_r;
                end
`endif
                DIVIDE: begin
                    if (!last) begin
                        rem_r <= rem_next;
                        q_r   <= {q_r[WIDTH-2:0], q_bit};
                        cnt   <= cnt - 1'b1;
                        last  <= (cnt == '0);
`ifndef BETA_DIV_SIGNED_EN
                    end else begin
                        // Commit cycle: results only ever change on entry to DONE.
                        quotient    <= dz_r ? DZ_QUOTIENT : q_r;
                        remainder   <= dz_r ? dividend_r : rem_r;
                        div_by_zero <= dz_r;
`endif
                    end
                end
`ifdef BETA_DIV_SIGNED_EN
                POST: begin
                    quotient    <= dz_r ? DZ_QUOTIENT : (sign_q ? -q_r : q_r);
                    remainder   <= dz_r ? dividend_r : (sign_r ? -rem_r : rem_r);
                    div_by_zero <= dz_r;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_beta_div.sv
// tb/tb_beta_div.sv - randomized self-checking bench for beta_div against an arithmetic reference model
module tb_beta_div;

    localparam int W = 32;
`ifdef BETA_DIV_SIGNED_EN
    localparam int LAT = W + 3;
`else
    localparam int LAT = W + 1;
`endif
    localparam int TIMEOUT = 200;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int failures = 0;

    beta_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        dz = (b == 0);
        if (b == 0) begin
            q = {W{1'b1}};
            r = a;
        end else begin
`ifdef BETA_DIV_SIGNED_EN
            if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) begin
                q = a;
                r = '0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endtask

    // Runs one operation to completion; lat counts edges from acceptance to out_valid.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk);
            #1 lat++;
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (quotient !== '0) begin failures++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
        checks++; if (remainder !== '0) begin failures++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        rst_n = 1'b1;
        // out_ready without a result must not disturb the idle block.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_ready got=%b%b exp=10", in_ready, out_valid); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[5], tb[5], eq[5], er[5];
        logic         ez[5];
        logic [W-1:0] q, r;
        logic         dz;
        int           lat;
`ifdef BETA_DIV_SIGNED_EN
        ta = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd9};
        tb = '{32'd7,   32'd2,         32'hFFFF_FFFF, 32'd0, 32'd3};
        eq = '{32'd14,  32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd3};
        er = '{32'd2,   32'hFFFF_FFFF, 32'd0,         32'd5, 32'd0};
`else
        ta = '{32'd100, 32'hFFFF_FFFF, 32'd3,         32'd5, 32'd9};
        tb = '{32'd7,   32'd1,         32'hFFFF_FFFF, 32'd0, 32'd3};
        eq = '{32'd14,  32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'd3};
        er = '{32'd2,   32'd0,         32'd3,         32'd5, 32'd0};
`endif
        ez = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], q, r, dz, lat);
            checks++; if (q !== eq[i]) begin failures++; $display("FAIL directed%0d_quotient got=%h exp=%h", i, q, eq[i]); end
            checks++; if (r !== er[i]) begin failures++; $display("FAIL directed%0d_remainder got=%h exp=%h", i, r, er[i]); end
            checks++; if (dz !== ez[i]) begin failures++; $display("FAIL directed%0d_dbz got=%b exp=%b", i, dz, ez[i]); end
            checks++; if (lat != LAT) begin failures++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, LAT); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, eq, er, q0, r0;
        logic         ez;
        int           lat;
        a = $urandom;
        b = $urandom_range(1, 1000);
        model(a, b, eq, er, ez);
        @(negedge clk);
        in_valid = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk);
            #1 lat++;
        end
        checks++; if (lat != LAT) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); end
        q0 = quotient;
        r0 = remainder;
        checks++; if (q0 !== eq || r0 !== er) begin failures++; $display("FAIL bp_result got=%h/%h exp=%h/%h", q0, r0, eq, er); end
        in_valid = 1'b1;
        dividend = a ^ 32'h5A5A_5A5A;
        divisor  = b + 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold%0d_flags got=%b%b exp=10", i, out_valid, in_ready); end
            checks++; if (quotient !== q0 || remainder !== r0) begin failures++; $display("FAIL bp_hold%0d_stable got=%h/%h exp=%h/%h", i, quotient, remainder, q0, r0); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b%b exp=10", in_ready, out_valid); end
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_no_ghost got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r;
        logic         dz;
        int           lat;
        @(negedge clk);
        in_valid = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midrst_flags got=%b%b exp=01", out_valid, in_ready); end
        checks++; if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin failures++; $display("FAIL midrst_outputs got=%h/%h/%b exp=0/0/0", quotient, remainder, div_by_zero); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd100, 32'd7, q, r, dz, lat);
        checks++; if (q !== 32'd14 || r !== 32'd2 || dz !== 1'b0) begin failures++; $display("FAIL midrst_redo got=%h/%h/%b exp=e/2/0", q, r, dz); end
        checks++; if (lat != LAT) begin failures++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, LAT); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er, q, r;
        logic         ez, dz;
        int           lat;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = $urandom_range(1, 15);
                2:       b = {W{1'b1}};
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = {1'b1, {(W-1){1'b0}}};
            model(a, b, eq, er, ez);
            do_op(a, b, q, r, dz, lat);
            checks++; if (q !== eq || r !== er || dz !== ez) begin failures++; $display("FAIL random%0d %h/%h got=%h/%h/%b exp=%h/%h/%b", i, a, b, q, r, dz, eq, er, ez); end
            checks++; if (lat != LAT) begin failures++; $display("FAIL random%0d_latency got=%0d exp=%0d", i, lat, LAT); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, eq, er, q, r;
        logic         ez, dz;
        int           lat;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom_range(1, 1 << 16);
            model(a, b, eq, er, ez);
            do_op(a, b, q, r, dz, lat);
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b%0d_idle got=%b%b exp=10", i, in_ready, out_valid); end
            checks++; if (q !== eq || r !== er || dz !== ez) begin failures++; $display("FAIL b2b%0d_result got=%h/%h/%b exp=%h/%h/%b", i, q, r, dz, eq, er, ez); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beta_div.md
# beta_div

Iterative restoring divider for the Beta ALU datapath. It accepts a dividend/divisor pair over a valid/ready handshake and computes one quotient bit per cycle. It returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake. It is the inverse-operation companion to the ALU's carry-lookahead adder and sits beside it behind the ALU function mux for DIV/MOD operations.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands (IDLE only)
- dividend  in  WIDTH  numerator
- divisor  in  WIDTH  denominator
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- quotient  out  WIDTH  result quotient
- remainder  out  WIDTH  result remainder
- div_by_zero  out  1  divisor was zero for this result

## Operation
- FSM states: IDLE, PRE (signed build only), DIVIDE, POST (signed build only), DONE.
- IDLE: in_ready=1. On in_valid the block:
  - latches the operands;
  - loads the partial remainder R=0, the quotient shift register Q=dividend and the divisor D;
  - sets the step counter to WIDTH-1;
  - goes to DIVIDE (or PRE).
- DIVIDE, each cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} − {1'b0, D}, a WIDTH+1-bit trial subtract.
  - If T is non-negative: R=T, shift 1 into Q.
  - Otherwise: R={R,Q msb}, shift 0 into Q.
  - Counter decrements. Leave to DONE (or POST) after the step with counter=0.
- DONE: out_valid=1. quotient, remainder and div_by_zero are held stable until out_valid&out_ready. Then return to IDLE.
- in_ready=0 in every state except IDLE. No overlap of consecutive operations.
- Divide by zero:
  - div_by_zero=1.
  - quotient=all ones, remainder=dividend as presented, in both builds.
  - Same latency as a normal divide.
- Unsigned width rules: quotient = floor(dividend/divisor), remainder = dividend − quotient·divisor, both WIDTH bits.

## Timing
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE.
- Latency, unsigned build: accept at edge 0; out_valid rises after edge WIDTH+1, i.e. WIDTH+1 cycles after acceptance.
- Latency, signed build: WIDTH+3 cycles.
- out_valid held indefinitely under out_ready=0. Result registers update only when entering DONE.
- in_valid while busy is ignored. The upstream must hold operands until in_ready.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values; no partial result ever appears.
- out_ready with out_valid=0 has no effect.

## Configuration
- BETA_DIV_SIGNED_EN defined:
  - Operands are two's complement.
  - PRE converts the operands to magnitudes and records sign_q = sign(dividend) xor sign(divisor) and sign_r = sign(dividend).
  - POST negates the quotient if sign_q and the remainder if sign_r.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN/−1 yields quotient=MIN, remainder=0.
  - Divide-by-zero override still applies.
- Undefined: unsigned only. PRE and POST states do not exist.

## Structure
- Shared package beta_alu_pkg holds:
  - the state enum (div_state_t);
  - the default width constant BETA_WIDTH=32;
  - the all-ones constant used for divide-by-zero quotients.
- One sub-module, beta_div_step. It is combinational: it takes R, the Q msb and D, and returns next R and the quotient bit. beta_div instantiates it once and holds the FSM, counter and registers.

## Test plan
- Unsigned, WIDTH=32: 100/7 -> quotient=14, remainder=2, div_by_zero=0; out_valid exactly 33 cycles after acceptance.
- 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0. Then 3/0xFFFFFFFF -> quotient=0, remainder=3.
- 5/0 -> div_by_zero=1, quotient=0xFFFFFFFF, remainder=5. The next op, 9/3, gives div_by_zero=0, quotient=3.
- Hold out_ready=0 for 10 cycles after out_valid:
  - result stable and in_ready=0 throughout;
  - a new in_valid is ignored until the handshake completes.
- Pulse rst_n low at step 12 of a divide -> out_valid=0 and in_ready=1 immediately. A fresh 100/7 then completes correctly.
- With BETA_DIV_SIGNED_EN:
  - −7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF;
  - 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0;
  - latency 35 cycles.
